// File: rtl/base_endian_skid_if.sv
// Handshake bundle for base_endian_skid: upstream beat channel (i_*) and
// downstream beat channel (o_*). Data is numbered MSB-first, byte k = [8k:8k+7].
// Optional parity signals exist only when BASE_ENDIAN_SKID_PAR_EN is defined.
interface base_endian_skid_if #(
   parameter int bytes = 8
);
   logic                 i_v;
   logic                 i_r;
   logic [0:8*bytes-1]   i_d;
   logic                 i_ctrl;
   logic                 o_v;
   logic                 o_r;
   logic [0:8*bytes-1]   o_d;
   logic                 o_ctrl;
`ifdef BASE_ENDIAN_SKID_PAR_EN
   logic [0:bytes-1]     i_p;
   logic [0:bytes-1]     o_p;
   logic                 o_perr;

   modport slave (
      input  i_v, i_d, i_ctrl, o_r, i_p,
      output i_r, o_v, o_d, o_ctrl, o_p, o_perr
   );
   modport master (
      output i_v, i_d, i_ctrl, o_r, i_p,
      input  i_r, o_v, o_d, o_ctrl, o_p, o_perr
   );
`else
   modport slave (
      input  i_v, i_d, i_ctrl, o_r,
      output i_r, o_v, o_d, o_ctrl
   );
   modport master (
      output i_v, i_d, i_ctrl, o_r,
      input  i_r, o_v, o_d, o_ctrl
   );
`endif
endinterface

// File: rtl/base_endian_skid.sv
// base_endian_skid: 2-entry in-order skid buffer with optional per-beat byte
// reversal. Beats are swapped on entry, so o_d/o_ctrl come straight from the
// head register. i_r and o_v are flops; i_r is additionally held low while
// reset is asserted so the upstream sees "not ready" during reset.
// Optional feature macro: BASE_ENDIAN_SKID_PAR_EN (per-byte even parity
// carried with the beat, plus a sticky parity-error flag).
module base_endian_skid #(
   parameter int bytes = 8
) (
   input  logic               clk,
   input  logic               reset,
   base_endian_skid_if.slave  bus
);

   localparam int W = 8 * bytes;

   logic [1:0]   count_q, count_d;
   logic [0:W-1] d0_q, d0_d, d1_q, d1_d;
   logic         c0_q, c0_d, c1_q, c1_d;
   logic         i_r_q, i_r_d;
   logic         o_v_q, o_v_d;
   logic         push, pop;
   logic [0:W-1] in_d;

   function automatic logic [0:W-1] swap_bytes(input logic [0:W-1] d);
      logic [0:W-1] r;
      for (int k = 0; k < bytes; k++) begin
         r[8*k +: 8] = d[8*(bytes-1-k) +: 8];
      end
      return r;
   endfunction

`ifdef BASE_ENDIAN_SKID_PAR_EN
   logic [0:bytes-1] p0_q, p0_d, p1_q, p1_d;
   logic [0:bytes-1] in_p;
   logic             perr_q, perr_d;
   logic             par_bad;

   function automatic logic [0:bytes-1] swap_bits(input logic [0:bytes-1] p);
      logic [0:bytes-1] r;
      for (int k = 0; k < bytes; k++) begin
         r[k] = p[bytes-1-k];
      end
      return r;
   endfunction

   function automatic logic [0:bytes-1] byte_par(input logic [0:W-1] d);
      logic [0:bytes-1] r;
      for (int k = 0; k < bytes; k++) begin
         r[k] = ^d[8*k +: 8];
      end
      return r;
   endfunction
`endif

   // Next-state of the two-slot buffer: slot 0 is always the head.
   always_comb begin
      push    = bus.i_v & i_r_q;
      pop     = o_v_q & bus.o_r;
      in_d    = bus.i_ctrl ? swap_bytes(bus.i_d) : bus.i_d;
      count_d = count_q;
      d0_d    = d0_q;
      d1_d    = d1_q;
      c0_d    = c0_q;
      c1_d    = c1_q;
`ifdef BASE_ENDIAN_SKID_PAR_EN
      in_p    = bus.i_ctrl ? swap_bits(bus.i_p) : bus.i_p;
      p0_d    = p0_q;
      p1_d    = p1_q;
      par_bad = |(bus.i_p ^ byte_par(bus.i_d));
      perr_d  = perr_q | (push & par_bad);
`endif
      case (count_q)
         2'd0: begin
            if (push) begin
               d0_d    = in_d;
               c0_d    = bus.i_ctrl;
`ifdef BASE_ENDIAN_SKID_PAR_EN
               p0_d    = in_p;
`endif
               count_d = 2'd1;
            end
         end
         2'd1: begin
            if (push && pop) begin
               d0_d = in_d;
               c0_d = bus.i_ctrl;
`ifdef BASE_ENDIAN_SKID_PAR_EN
               p0_d = in_p;
`endif
            end else if (pop) begin
               count_d = 2'd0;
            end else if (push) begin
               d1_d    = in_d;
               c1_d    = bus.i_ctrl;
`ifdef BASE_ENDIAN_SKID_PAR_EN
               p1_d    = in_p;
`endif
               count_d = 2'd2;
            end
         end
         2'd2: begin
            if (pop) begin
               d0_d    = d1_q;
               c0_d    = c1_q;
`ifdef BASE_ENDIAN_SKID_PAR_EN
               p0_d    = p1_q;
`endif
               count_d = 2'd1;
            end
         end
         default: count_d = 2'd0;
      endcase
      i_r_d = (count_d != 2'd2);
      o_v_d = (count_d != 2'd0);
   end

   // Buffer registers with synchronous reset that discards any stored beats.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= 2'd0;
         d0_q    <= '0;
         d1_q    <= '0;
         c0_q    <= 1'b0;
         c1_q    <= 1'b0;
         i_r_q   <= 1'b1;
         o_v_q   <= 1'b0;
`ifdef BASE_ENDIAN_SKID_PAR_EN
         p0_q    <= '0;
         p1_q    <= '0;
         perr_q  <= 1'b0;
`endif
      end else begin
         count_q <= count_d;
         d0_q    <= d0_d;
         d1_q    <= d1_d;
         c0_q    <= c0_d;
         c1_q    <= c1_d;
         i_r_q   <= i_r_d;
         o_v_q   <= o_v_d;
`ifdef BASE_ENDIAN_SKID_PAR_EN
         p0_q    <= p0_d;
         p1_q    <= p1_d;
         perr_q  <= perr_d;
`endif
      end
   end

   assign bus.i_r    = i_r_q & ~reset;
   assign bus.o_v    = o_v_q;
   assign bus.o_d    = d0_q;
   assign bus.o_ctrl = c0_q;
`ifdef BASE_ENDIAN_SKID_PAR_EN
   assign bus.o_p    = p0_q;
   assign bus.o_perr = perr_q;
`endif

endmodule
